clk_div_checker: RTL and testbench

- Monitors a divided clock produced in the same `clk` domain, for example the output of the divide-by-4 block.
- Measures the period and high time of each cycle of that divided clock, in `clk` cycles, and checks both against the expected divide ratio.
- Declares lock after a run of good periods; flags period/duty errors and a stuck input.
- Sits beside clock-divider blocks as a built-in self-check, and is also usable as a bench monitor.

---
 rtl/clk_div_checker.sv | 169 ++++++++++++++++
 tb/tb_clk_div_checker.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_checker.sv
// Period / duty monitor for a divided clock generated in the clk domain.
// Measures each divided-clock cycle, declares lock after a run of good periods, and flags errors.
module clk_div_checker #(
   parameter int DIV      = 4,
   parameter int CNT_W    = 8,
   parameter int LOCK_CNT = 4,
   parameter int ERR_W    = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             div_clk_in,
   input  logic             clr_err,
   output logic             meas_valid,
   output logic [CNT_W-1:0] period_out,
   output logic [CNT_W-1:0] high_out,
   output logic             locked,
   output logic             err_sticky,
   output logic             stuck,
   output logic [ERR_W-1:0] err_cnt
);

   localparam int GOOD_W = (LOCK_CNT > 1) ? $clog2(LOCK_CNT) : 1;
   localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_CNT - 1);
   localparam logic [CNT_W-1:0]  PER_EXP   = CNT_W'(DIV);
   localparam logic [CNT_W-1:0]  HI_LO     = CNT_W'(DIV / 2);
   localparam logic [CNT_W-1:0]  HI_HI     = CNT_W'(DIV / 2 + DIV % 2);
   localparam logic [CNT_W-1:0]  TIMEOUT   = CNT_W'(2 * DIV);

   typedef enum logic [1:0] {IDLE, SEEK, MEASURE, LOCKED} state_t;

   state_t             state, state_nxt;
   logic               d_q;
   logic [CNT_W-1:0]   per_cnt, per_nxt;
   logic [CNT_W-1:0]   hi_cnt, hi_nxt;
   logic [GOOD_W-1:0]  good_cnt, good_nxt;
   logic               meas_nxt, locked_nxt, sticky_nxt, stuck_nxt;
   logic [CNT_W-1:0]   period_nxt, high_nxt;
   logic [ERR_W-1:0]   err_nxt;
   logic               rise, good, err_evt;

   function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] v);
      return (v == '1) ? v : v + CNT_W'(1);
   endfunction

   function automatic logic [ERR_W-1:0] err_inc(input logic [ERR_W-1:0] v);
      return (v == '1) ? v : v + ERR_W'(1);
   endfunction

   assign rise = div_clk_in & ~d_q;
   // Counts as they stand at the rise are exactly what gets reported.
   assign good = (per_cnt == PER_EXP) && ((hi_cnt == HI_LO) || (hi_cnt == HI_HI));

   always_comb begin
      state_nxt  = state;
      per_nxt    = per_cnt;
      hi_nxt     = hi_cnt;
      good_nxt   = good_cnt;
      meas_nxt   = 1'b0;
      period_nxt = period_out;
      high_nxt   = high_out;
      locked_nxt = locked;
      sticky_nxt = err_sticky;
      err_nxt    = err_cnt;
      stuck_nxt  = 1'b0;
      err_evt    = 1'b0;

      if (!en) begin
         state_nxt  = IDLE;
         locked_nxt = 1'b0;
         per_nxt    = '0;
         hi_nxt     = '0;
         good_nxt   = '0;
      end else if (state == IDLE) begin
         per_nxt   = '0;
         hi_nxt    = '0;
         good_nxt  = '0;
         state_nxt = SEEK;
      end else begin
         if (rise) begin
            per_nxt = CNT_W'(1);
            hi_nxt  = CNT_W'(1);
         end else begin
            per_nxt = cnt_inc(per_cnt);
            hi_nxt  = div_clk_in ? cnt_inc(hi_cnt) : hi_cnt;
         end

         case (state)
            SEEK: begin
               if (rise) begin
                  good_nxt  = '0;
                  state_nxt = MEASURE;
               end
            end
            MEASURE, LOCKED: begin
               // Timeout wins over a coincident rise.
               if (per_cnt >= TIMEOUT) begin
                  stuck_nxt  = 1'b1;
                  err_evt    = 1'b1;
                  locked_nxt = 1'b0;
                  good_nxt   = '0;
                  state_nxt  = SEEK;
               end else if (rise) begin
                  meas_nxt   = 1'b1;
                  period_nxt = per_cnt;
                  high_nxt   = hi_cnt;
                  if (good) begin
                     if (state == MEASURE) begin
                        if (good_cnt == GOOD_LAST) begin
                           good_nxt   = '0;
                           locked_nxt = 1'b1;
                           state_nxt  = LOCKED;
                        end else begin
                           good_nxt = good_cnt + GOOD_W'(1);
                        end
                     end
                  end else begin
                     err_evt    = 1'b1;
                     good_nxt   = '0;
                     locked_nxt = 1'b0;
                     state_nxt  = MEASURE;
                  end
               end
            end
            default: state_nxt = IDLE;
         endcase
      end

      // A new error beats a simultaneous clear.
      if (err_evt) begin
         sticky_nxt = 1'b1;
         err_nxt    = clr_err ? ERR_W'(1) : err_inc(err_cnt);
      end else if (clr_err) begin
         sticky_nxt = 1'b0;
         err_nxt    = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         d_q        <= 1'b0;
         per_cnt    <= '0;
         hi_cnt     <= '0;
         good_cnt   <= '0;
         meas_valid <= 1'b0;
         period_out <= '0;
         high_out   <= '0;
         locked     <= 1'b0;
         err_sticky <= 1'b0;
         stuck      <= 1'b0;
         err_cnt    <= '0;
      end else begin
         state      <= state_nxt;
         d_q        <= div_clk_in;
         per_cnt    <= per_nxt;
         hi_cnt     <= hi_nxt;
         good_cnt   <= good_nxt;
         meas_valid <= meas_nxt;
         period_out <= period_nxt;
         high_out   <= high_nxt;
         locked     <= locked_nxt;
         err_sticky <= sticky_nxt;
         stuck      <= stuck_nxt;
         err_cnt    <= err_nxt;
      end
   end

endmodule

// File: tb/tb_clk_div_checker.sv
// Directed bench for clk_div_checker: DIV=4 and DIV=3 instances driven from period tables
// plus hand-written timeout, enable-drop and reset sequences.
module tb_clk_div_checker;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en4 = 1'b0, div4 = 1'b0, clr4 = 1'b0;
   logic       en3 = 1'b0, div3 = 1'b0, clr3 = 1'b0;
   logic       m4, lk4, st4, sk4, m3, lk3, st3, sk3;
   logic [7:0] per4, hi4, ec4, per3, hi3, ec3;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   clk_div_checker #(.DIV(4), .CNT_W(8), .LOCK_CNT(4), .ERR_W(8)) dut4 (
      .clk(clk), .rst(rst), .en(en4), .div_clk_in(div4), .clr_err(clr4),
      .meas_valid(m4), .period_out(per4), .high_out(hi4), .locked(lk4),
      .err_sticky(st4), .stuck(sk4), .err_cnt(ec4));

   clk_div_checker #(.DIV(3), .CNT_W(8), .LOCK_CNT(4), .ERR_W(8)) dut3 (
      .clk(clk), .rst(rst), .en(en3), .div_clk_in(div3), .clr_err(clr3),
      .meas_valid(m3), .period_out(per3), .high_out(hi3), .locked(lk3),
      .err_sticky(st3), .stuck(sk3), .err_cnt(ec3));

   // One record per divided-clock cycle: high h cycles then low (p-h) cycles.
   // Expected values are those seen right after the rise that opens the record.
   typedef struct {
      bit sel;
      int h;
      int p;
      bit clr;
      bit m;
      int per;
      int hi;
      bit lk;
      bit st;
      int ec;
   } rec_t;

   rec_t tbl[$];

   task automatic add(input bit sel, input int h, input int p, input bit clr, input bit m,
                      input int per, input int hi, input bit lk, input bit st, input int ec);
      rec_t r;
      r.sel = sel; r.h = h; r.p = p; r.clr = clr; r.m = m;
      r.per = per; r.hi = hi; r.lk = lk; r.st = st; r.ec = ec;
      tbl.push_back(r);
   endtask

   task automatic chk(input string nm, input int act, input int exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic step4(input bit d);
      div4 = d;
      @(posedge clk);
      #1;
   endtask

   task automatic run_rec(input int idx);
      rec_t r;
      r = tbl[idx];
      for (int c = 0; c < r.p; c++) begin
         if (r.sel) begin div3 = (c < r.h); clr3 = (c == 0) && r.clr; end
         else       begin div4 = (c < r.h); clr4 = (c == 0) && r.clr; end
         @(posedge clk);
         #1;
         if (c == 0) begin
            chk($sformatf("rec%0d meas_valid", idx), r.sel ? int'(m3) : int'(m4), int'(r.m));
            if (r.m) begin
               chk($sformatf("rec%0d period", idx), r.sel ? int'(per3) : int'(per4), r.per);
               chk($sformatf("rec%0d high", idx), r.sel ? int'(hi3) : int'(hi4), r.hi);
            end
            chk($sformatf("rec%0d locked", idx), r.sel ? int'(lk3) : int'(lk4), int'(r.lk));
            chk($sformatf("rec%0d err_sticky", idx), r.sel ? int'(st3) : int'(st4), int'(r.st));
            chk($sformatf("rec%0d err_cnt", idx), r.sel ? int'(ec3) : int'(ec4), r.ec);
         end
      end
      clr3 = 1'b0;
      clr4 = 1'b0;
   endtask

   task automatic run_range(input int first, input int last);
      for (int i = first; i <= last; i++) run_rec(i);
   endtask

   task automatic chk_zero4(input string tag);
      chk({tag, " meas_valid"}, int'(m4), 0);
      chk({tag, " period"}, int'(per4), 0);
      chk({tag, " high"}, int'(hi4), 0);
      chk({tag, " locked"}, int'(lk4), 0);
      chk({tag, " err_sticky"}, int'(st4), 0);
      chk({tag, " stuck"}, int'(sk4), 0);
      chk({tag, " err_cnt"}, int'(ec4), 0);
   endtask

   initial begin
      // P1: lock, one long period, relock (idx 0..10)
      add(0, 2, 4, 0, 0, 0, 0, 0, 0, 0);
      add(0, 2, 4, 0, 1, 4, 2, 0, 0, 0);
      add(0, 2, 4, 0, 1, 4, 2, 0, 0, 0);
      add(0, 2, 4, 0, 1, 4, 2, 0, 0, 0);
      add(0, 2, 4, 0, 1, 4, 2, 1, 0, 0);
      add(0, 2, 5, 0, 1, 4, 2, 1, 0, 0);
      add(0, 2, 4, 0, 1, 5, 2, 0, 1, 1);
      add(0, 2, 4, 0, 1, 4, 2, 0, 1, 1);
      add(0, 2, 4, 0, 1, 4, 2, 0, 1, 1);
      add(0, 2, 4, 0, 1, 4, 2, 0, 1, 1);
      add(0, 2, 4, 0, 1, 4, 2, 1, 1, 1);
      // P2: after timeout (SEEK), clear, clear colliding with error, relock (idx 11..19)
      add(0, 2, 4, 0, 0, 0, 0, 0, 1, 2);
      add(0, 2, 4, 0, 1, 4, 2, 0, 1, 2);
      add(0, 2, 5, 1, 1, 4, 2, 0, 0, 0);
      add(0, 2, 5, 0, 1, 5, 2, 0, 1, 1);
      add(0, 2, 4, 1, 1, 5, 2, 0, 1, 1);
      add(0, 2, 4, 0, 1, 4, 2, 0, 1, 1);
      add(0, 2, 4, 0, 1, 4, 2, 0, 1, 1);
      add(0, 2, 4, 0, 1, 4, 2, 0, 1, 1);
      add(0, 2, 4, 0, 1, 4, 2, 1, 1, 1);
      // P3: after enable drop, relock (idx 20..24)
      add(0, 2, 4, 0, 0, 0, 0, 0, 1, 1);
      add(0, 2, 4, 0, 1, 4, 2, 0, 1, 1);
      add(0, 2, 4, 0, 1, 4, 2, 0, 1, 1);
      add(0, 2, 4, 0, 1, 4, 2, 0, 1, 1);
      add(0, 2, 4, 0, 1, 4, 2, 1, 1, 1);
      // P4: after reset, first rise is a SEEK rise (idx 25..26)
      add(0, 2, 4, 0, 0, 0, 0, 0, 0, 0);
      add(0, 2, 4, 0, 1, 4, 2, 0, 0, 0);
      // P5: DIV=3, pattern 0,1,1 locks, then 0,0,0,1 keeps failing (idx 27..35)
      add(1, 2, 3, 0, 0, 0, 0, 0, 0, 0);
      add(1, 2, 3, 0, 1, 3, 2, 0, 0, 0);
      add(1, 2, 3, 0, 1, 3, 2, 0, 0, 0);
      add(1, 2, 3, 0, 1, 3, 2, 0, 0, 0);
      add(1, 2, 3, 0, 1, 3, 2, 1, 0, 0);
      add(1, 1, 4, 0, 1, 3, 2, 1, 0, 0);
      add(1, 1, 4, 0, 1, 4, 1, 0, 1, 1);
      add(1, 1, 4, 0, 1, 4, 1, 0, 1, 2);
      add(1, 1, 4, 0, 1, 4, 1, 0, 1, 3);

      // Reset state
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk_zero4("reset");
      rst = 1'b0;
      en4 = 1'b1;
      step4(1'b0);

      run_range(0, 10);

      // Hold input low while locked: stuck 8 cycles after the last rise
      for (int k = 4; k < 8; k++) begin
         step4(1'b0);
         chk($sformatf("hold%0d stuck", k), int'(sk4), 0);
         chk($sformatf("hold%0d locked", k), int'(lk4), 1);
      end
      step4(1'b0);
      chk("timeout stuck", int'(sk4), 1);
      chk("timeout locked", int'(lk4), 0);
      chk("timeout err_sticky", int'(st4), 1);
      chk("timeout err_cnt", int'(ec4), 2);
      step4(1'b0);
      chk("timeout stuck pulse ends", int'(sk4), 0);

      run_range(11, 19);

      // Drop enable while locked
      en4 = 1'b0;
      step4(1'b1);
      chk("en_low locked", int'(lk4), 0);
      chk("en_low meas_valid", int'(m4), 0);
      chk("en_low err_cnt", int'(ec4), 1);
      chk("en_low err_sticky", int'(st4), 1);
      step4(1'b0);
      chk("en_low held locked", int'(lk4), 0);
      en4 = 1'b1;
      step4(1'b0);

      run_range(20, 24);

      // Reset mid-period while locked
      step4(1'b1);
      chk("pre_rst locked", int'(lk4), 1);
      step4(1'b1);
      rst = 1'b1;
      step4(1'b0);
      chk_zero4("mid_rst");
      rst = 1'b0;
      step4(1'b0);

      run_range(25, 26);

      // DIV=3 instance
      en3 = 1'b1;
      div3 = 1'b0;
      @(posedge clk); #1;
      run_range(27, 35);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
